// File: rtl/kpyd_pkg.sv
// Shared keypad constants and key-map helpers for the keypad emulator and the scanner.
// Columns and rows are active-low one-hot.
package kpyd_pkg;

   typedef enum logic [1:0] {
      KPYD_IDLE  = 2'd0,
      KPYD_PRESS = 2'd1,
      KPYD_GAP   = 2'd2
   } kpyd_emu_state_t;

   localparam logic [3:0] ROW_IDLE = 4'b1111;

   localparam logic [3:0] C1 = 4'b0111;
   localparam logic [3:0] C2 = 4'b1011;
   localparam logic [3:0] C3 = 4'b1101;
   localparam logic [3:0] C4 = 4'b1110;

   localparam logic [3:0] R1 = 4'b0111;
   localparam logic [3:0] R2 = 4'b1011;
   localparam logic [3:0] R3 = 4'b1101;
   localparam logic [3:0] R4 = 4'b1110;

   // One response-pipeline entry: the column strobe, the press flag and the key it belongs to.
   typedef struct packed {
      logic [3:0] col;
      logic       act;
      logic [3:0] code;
   } kpyd_pipe_t;

   localparam kpyd_pipe_t PIPE_CLR = '{col: ROW_IDLE, act: 1'b0, code: 4'h0};

   function automatic logic [3:0] kpyd_key_col(input logic [3:0] code);
      case (code)
         4'h1, 4'h4, 4'h7, 4'h0: kpyd_key_col = C1;
         4'h2, 4'h5, 4'h8, 4'hF: kpyd_key_col = C2;
         4'h3, 4'h6, 4'h9, 4'hE: kpyd_key_col = C3;
         default:                kpyd_key_col = C4;
      endcase
   endfunction

   function automatic logic [3:0] kpyd_key_row(input logic [3:0] code);
      case (code)
         4'h1, 4'h2, 4'h3, 4'hA: kpyd_key_row = R1;
         4'h4, 4'h5, 4'h6, 4'hB: kpyd_key_row = R2;
         4'h7, 4'h8, 4'h9, 4'hC: kpyd_key_row = R3;
         default:                kpyd_key_row = R4;
      endcase
   endfunction

endpackage

// File: rtl/kpyd_emulator_if.sv
// Key request handshake plus the keypad Col/Row matrix, as seen by the emulator (slave)
// and by whoever feeds it keys and scans it (master).
interface kpyd_emulator_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic [3:0] Col;
   logic [3:0] Row;
   logic       pressed;
   logic       busy;

   modport slave (
      input  key_valid, key_code, Col,
      output key_ready, Row, pressed, busy
   );

   modport master (
      output key_valid, key_code, Col,
      input  key_ready, Row, pressed, busy
   );
endinterface

// File: rtl/kpyd_row_pipe.sv
// STAGES-deep register delay of {Col, press flag, key}, cleared asynchronously to an
// idle entry so nothing stale reaches Row after reset.
module kpyd_row_pipe
   import kpyd_pkg::*;
#(
   parameter int STAGES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  kpyd_pipe_t in_d,
   output kpyd_pipe_t out_q
);

   generate
      if (STAGES == 0) begin : g_thru
         assign out_q = in_d;
      end else begin : g_reg
         kpyd_pipe_t stg_q [STAGES];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < STAGES; i++) stg_q[i] <= PIPE_CLR;
            end else begin
               stg_q[0] <= in_d;
               for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
            end
         end

         assign out_q = stg_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/kpyd_emulator.sv
// Synthesisable 4x4 keypad responder: presses one queued key at a time for HOLD_CYCLES,
// releases for GAP_CYCLES, and answers the scanner's column strobe RESP_DLY cycles later.
module kpyd_emulator
   import kpyd_pkg::*;
#(
   parameter logic [23:0] HOLD_CYCLES = 24'd1_000_000,
   parameter logic [23:0] GAP_CYCLES  = 24'd500_000,
   parameter int          RESP_DLY    = 2   // 1..7: the scanner samples Row 8 cycles after Col
) (
   input  logic              clk,
   input  logic              rst_n,
   kpyd_emulator_if.slave    kif
);

   localparam logic [23:0] HOLD_LD = (HOLD_CYCLES == 24'd0) ? 24'd0 : HOLD_CYCLES - 24'd1;
   localparam logic [23:0] GAP_LD  = (GAP_CYCLES == 24'd0) ? 24'd0 : GAP_CYCLES - 24'd1;

   kpyd_emu_state_t state_q, state_d;
   logic [23:0]     cnt_q, cnt_d;
   logic [3:0]      code_q, code_d;
   logic [3:0]      row_q, row_d;
   kpyd_pipe_t      pipe_in, pipe_out;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      case (state_q)
         KPYD_IDLE: begin
            if (kif.key_valid) begin
               code_d  = kif.key_code;
               cnt_d   = HOLD_LD;
               state_d = KPYD_PRESS;
            end
         end
         KPYD_PRESS: begin
            if (cnt_q == 24'd0) begin
               if (GAP_CYCLES != 24'd0) begin
                  cnt_d   = GAP_LD;
                  state_d = KPYD_GAP;
               end else begin
                  state_d = KPYD_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 24'd1;
            end
         end
         KPYD_GAP: begin
            if (cnt_q == 24'd0) state_d = KPYD_IDLE;
            else                cnt_d   = cnt_q - 24'd1;
         end
         default: state_d = KPYD_IDLE;
      endcase
   end

   // The key code travels with its strobe so a fast follow-up key cannot
   // reinterpret entries still in flight for the previous one.
   assign pipe_in = '{col: kif.Col, act: (state_q == KPYD_PRESS), code: code_q};

   kpyd_row_pipe #(.STAGES(RESP_DLY - 1)) u_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .in_d  (pipe_in),
      .out_q (pipe_out)
   );

   // Exact match against the key's one-hot column rejects idle or multi-column strobes.
   always_comb begin
      row_d = ROW_IDLE;
      if (pipe_out.act && (pipe_out.col == kpyd_key_col(pipe_out.code)))
         row_d = kpyd_key_row(pipe_out.code);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= KPYD_IDLE;
         cnt_q   <= 24'd0;
         code_q  <= 4'h0;
         row_q   <= ROW_IDLE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         row_q   <= row_d;
      end
   end

   assign kif.key_ready = rst_n && (state_q == KPYD_IDLE);
   assign kif.pressed   = (state_q == KPYD_PRESS);
   assign kif.busy      = (state_q == KPYD_PRESS) || (state_q == KPYD_GAP);
   assign kif.Row       = row_q;

endmodule

// File: tb/tb_kpyd_emulator.sv
// Two emulators (HOLD=10/GAP=4/DLY=2 and HOLD=0/GAP=0/DLY=3) driven each cycle; expected
// outputs come from a timeline model of press windows and a keypad grid lookup.
module tb_kpyd_emulator;

   localparam int MAXC = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   kpyd_emulator_if ifa ();
   kpyd_emulator_if ifb ();

   kpyd_emulator #(.HOLD_CYCLES(24'd10), .GAP_CYCLES(24'd4), .RESP_DLY(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .kif(ifa));
   kpyd_emulator #(.HOLD_CYCLES(24'd0), .GAP_CYCLES(24'd0), .RESP_DLY(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .kif(ifb));

   typedef struct packed {
      logic [3:0] row;
      logic       pr;
      logic       bz;
      logic       rd;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t me;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   // grid[column][row], column 0 = leftmost strobe 0111, row 0 = return 0111
   int grid [4][4] = '{'{1, 4, 7, 0}, '{2, 5, 8, 15}, '{3, 6, 9, 14}, '{10, 11, 12, 13}};

   int H [2] = '{10, 1};
   int G [2] = '{4, 0};
   int D [2] = '{2, 3};

   int         ready_from [2];
   int         pstart     [2];
   int         bnd        [2];
   logic [3:0] code_lat   [2];
   logic [3:0] hcol  [2][MAXC];
   logic       hact  [2][MAXC];
   logic [3:0] hcode [2][MAXC];

   logic       kv   [2];
   logic [3:0] kc   [2];
   logic [3:0] kcol [2];

   logic [3:0] colset [8] = '{4'h7, 4'hB, 4'hD, 4'hE, 4'hF, 4'h3, 4'h0, 4'h5};

   function automatic logic [3:0] ref_row(input logic [3:0] col, input logic a,
                                          input logic [3:0] code);
      logic [3:0] cm, rm;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            cm = 4'b1000 >> c;
            rm = 4'b1000 >> r;
            if (a && grid[c][r] == int'(code) && col == ~cm) return ~rm;
         end
      return 4'hF;
   endfunction

   task automatic chk(input string nm, input int i, input logic [3:0] got, input logic [3:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s dut%0d cyc %0d: got %h want %h", nm, i, cyc, got, want);
      end
   endtask

   task automatic drive();
      ifa.key_valid = kv[0]; ifa.key_code = kc[0]; ifa.Col = kcol[0];
      ifb.key_valid = kv[1]; ifb.key_code = kc[1]; ifb.Col = kcol[1];
   endtask

   task automatic step();
      exp_t e;
      int   m;
      @(posedge clk); #1;
      cyc++;
      drive();
      for (int i = 0; i < 2; i++) begin
         e.pr = (cyc >= pstart[i]) && (cyc < pstart[i] + H[i]);
         e.bz = (cyc >= pstart[i]) && (cyc < pstart[i] + H[i] + G[i]);
         e.rd = (cyc >= ready_from[i]);
         m = cyc - D[i];
         e.row = (m >= bnd[i]) ? ref_row(hcol[i][m], hact[i][m], hcode[i][m]) : 4'hF;
         if (i == 0) qa.push_back(e); else qb.push_back(e);
         hcol[i][cyc]  = kcol[i];
         hact[i][cyc]  = e.pr;
         hcode[i][cyc] = code_lat[i];
         if (kv[i] && e.rd) begin
            pstart[i]     = cyc + 1;
            ready_from[i] = cyc + H[i] + G[i] + 1;
            code_lat[i]   = kc[i];
         end
      end
   endtask

   task automatic rand_b();
      logic [3:0] one;
      one     = 4'b1000 >> $urandom_range(3);
      kv[1]   = ($urandom_range(3) != 0);
      kc[1]   = 4'($urandom);
      kcol[1] = ~one;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         rand_b();
         step();
         kv[0] = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin kv[i] = 1'b0; kc[i] = 4'h0; kcol[i] = 4'hF; end
      drive();
      #1;
      chk("rst_row", 0, ifa.Row, 4'hF);
      chk("rst_row", 1, ifb.Row, 4'hF);
      chk("rst_flags", 0, {1'b0, ifa.pressed, ifa.busy, ifa.key_ready}, 4'h0);
      chk("rst_flags", 1, {1'b0, ifb.pressed, ifb.busy, ifb.key_ready}, 4'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bnd[i]        = cyc + 1;
         ready_from[i] = cyc + 1;
         pstart[i]     = -1000;
      end
   endtask

   always @(negedge clk) begin
      if (qa.size() != 0) begin
         me = qa.pop_front();
         chk("row", 0, ifa.Row, me.row);
         chk("pressed", 0, {3'b0, ifa.pressed}, {3'b0, me.pr});
         chk("busy", 0, {3'b0, ifa.busy}, {3'b0, me.bz});
         chk("key_ready", 0, {3'b0, ifa.key_ready}, {3'b0, me.rd});
      end
      if (qb.size() != 0) begin
         me = qb.pop_front();
         chk("row", 1, ifb.Row, me.row);
         chk("pressed", 1, {3'b0, ifb.pressed}, {3'b0, me.pr});
         chk("busy", 1, {3'b0, ifb.busy}, {3'b0, me.bz});
         chk("key_ready", 1, {3'b0, ifb.key_ready}, {3'b0, me.rd});
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         code_lat[i] = 4'h0; kv[i] = 1'b0; kc[i] = 4'h0; kcol[i] = 4'hF;
      end
      drive();
      do_reset();

      // key 5 with its own column held
      kv[0] = 1'b1; kc[0] = 4'h5; kcol[0] = 4'b1011;
      run(20);

      // key D while sweeping every column
      kv[0] = 1'b1; kc[0] = 4'hD; kcol[0] = 4'b0111;
      run(1);
      kcol[0] = 4'b0111; run(2);
      kcol[0] = 4'b1011; run(2);
      kcol[0] = 4'b1101; run(2);
      kcol[0] = 4'b1110; run(3);
      kcol[0] = 4'hF;    run(6);

      // key 1 against illegal strobes, then its real column
      kv[0] = 1'b1; kc[0] = 4'h1; kcol[0] = 4'b0011;
      run(3);
      kcol[0] = 4'b1111; run(3);
      kcol[0] = 4'b0111; run(4);
      kcol[0] = 4'b0000; run(5);

      // reset in the middle of key 8 on C2
      kv[0] = 1'b1; kc[0] = 4'h8; kcol[0] = 4'b1011;
      run(6);
      do_reset();
      run(4);

      // randomized traffic with one reset partway through
      for (int k = 0; k < 1400; k++) begin
         kv[0]   = ($urandom_range(2) == 0);
         kc[0]   = 4'($urandom);
         if ($urandom_range(3) == 0) kcol[0] = colset[$urandom_range(7)];
         rand_b();
         step();
         if (k == 700) do_reset();
      end

      for (int i = 0; i < 2; i++) begin kv[i] = 1'b0; kcol[i] = 4'hF; end
      repeat (6) step();
      @(negedge clk); #1;
      if (qa.size() != 0 || qb.size() != 0) begin
         nerr++;
         $display("FAIL scoreboard_drain: got %0d/%0d entries left want 0", qa.size(), qb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
